// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage with a single outstanding memory request.
// A four-state FSM (IDLE, REQ, WAIT, HOLD) presents the current PC to
// instruction memory and waits for the returned word. It then holds that
// word for decode until decode consumes it.
//
// A redirect (branchEnable) flushes any held instruction and restarts
// fetching from pc_in. If a request is still in flight when the redirect
// arrives, a drop flag is set. That flag causes the late response to be
// discarded. While the drop flag is set no new request is issued, so the
// memory never sees more than one outstanding request.
//
// Ports
//   clk            : clock, all state changes on the rising edge
//   rst            : synchronous active-high reset
//   pc_in          : PC to fetch / redirect target
//   pc_advance     : one-cycle pulse when a request is accepted
//   branchEnable   : redirect / flush strobe
//   imem_req_valid : request presented to instruction memory
//   imem_req_ready : instruction memory accepts the request
//   imem_addr      : request address (zero when no request is presented)
//   imem_rsp_valid : instruction memory returns a word
//   imem_rsp_data  : returned instruction word
//   id_valid       : id_instr/id_pc hold a valid instruction
//   id_ready       : decode consumes the instruction
//   id_instr       : instruction word for decode
//   id_pc          : address id_instr was fetched from
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_advance,
  input  logic            branchEnable,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t          state, state_next;
  logic            drop, drop_next;
  logic            id_valid_next;
  logic [XLEN-1:0] id_instr_next, id_pc_next;
  logic [XLEN-1:0] pending_pc, pending_pc_next;
  logic            rsp_load;

  // The request is suppressed while a stale response is still owed.
  // It is also gated by rst, so that reset overrides any handshake
  // in the same cycle.
  always_comb begin
    imem_req_valid = (state == REQ) && !drop && !rst;
    imem_addr      = imem_req_valid ? pc_in : '0;
    pc_advance     = imem_req_valid && imem_req_ready;
  end

  // Next-state logic. The redirect is applied last, so it overrides the
  // normal progression of every state.
  always_comb begin
    state_next      = state;
    drop_next       = drop;
    id_valid_next   = id_valid;
    id_instr_next   = id_instr;
    id_pc_next      = id_pc;
    pending_pc_next = pending_pc;
    rsp_load        = (state == WAIT) && imem_rsp_valid && !branchEnable;

    // A response that was owed to a flushed request is swallowed here.
    if (drop && imem_rsp_valid) begin
      drop_next = 1'b0;
    end

    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        if (pc_advance) begin
          pending_pc_next = pc_in;
          state_next      = WAIT;
        end
      end
      WAIT: begin
        if (rsp_load) begin
          id_instr_next = imem_rsp_data;
          id_pc_next    = pending_pc;
          id_valid_next = 1'b1;
          state_next    = HOLD;
        end
      end
      HOLD: begin
        if (id_valid && id_ready) begin
          id_valid_next = 1'b0;
          state_next    = REQ;
        end
      end
      default: state_next = IDLE;
    endcase

    // A request is still in flight when either of these is true:
    //   - we are waiting and the response has not arrived in this cycle;
    //   - the request is being accepted in this very cycle.
    // In either case, the response that eventually arrives must be dropped.
    if (branchEnable) begin
      id_valid_next = 1'b0;
      state_next    = REQ;
      if ((state == WAIT && !imem_rsp_valid) || (state == REQ && pc_advance)) begin
        drop_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      drop       <= 1'b0;
      id_valid   <= 1'b0;
      id_instr   <= '0;
      id_pc      <= '0;
      pending_pc <= '0;
    end else begin
      state      <= state_next;
      drop       <= drop_next;
      id_valid   <= id_valid_next;
      id_instr   <= id_instr_next;
      id_pc      <= id_pc_next;
      pending_pc <= pending_pc_next;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed scenarios drive a fetch_stage instance. Each instruction that
// should reach decode is pushed into a scoreboard queue at the moment its
// memory response is driven. A negedge monitor pops the queue on every
// decode handshake and compares id_pc/id_instr against the popped entry.
// Responses that should be dropped are never pushed.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_advance;
  logic        branchEnable;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_entry_t;

  sb_entry_t sb[$];
  sb_entry_t mon_e;
  int assert_count = 0;
  int fail_count   = 0;
  int adv_count    = 0;
  int exp_adv      = 0;
  int cyc          = 0;
  int last_accept  = 0;
  int first_accept = 0;
  int adv_before   = 0;

  fetch_stage #(.XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .pc_advance     (pc_advance),
    .branchEnable   (branchEnable),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Counts pc_advance pulses. Also checks every decode handshake against
  // the scoreboard.
  always @(negedge clk) begin
    if (pc_advance) adv_count <= adv_count + 1;
    if (!rst && id_valid && id_ready) begin
      if (sb.size() == 0) begin
        checkOutput("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("sb_id_pc", id_pc, mon_e.pc);
        checkOutput("sb_id_instr", id_instr, mon_e.instr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait, with a bound, until a request is presented. Returns at
  // posedge+2.
  task automatic waitReq();
    int n = 0;
    #1;
    while (!imem_req_valid && n < 20) begin
      tick();
      #1;
      n++;
    end
    checkOutput("req_valid", {31'd0, imem_req_valid}, 32'd1);
  endtask

  // Fetch one instruction. The memory stalls the request for rdy_wait
  // cycles and answers rsp_lat cycles after acceptance. If deliver is set,
  // the instruction is expected to reach decode through the scoreboard.
  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] data,
                               input int rdy_wait, input int rsp_lat,
                               input bit deliver);
    pc_in          = pc;
    imem_req_ready = 1'b0;
    waitReq();
    for (int i = 0; i < rdy_wait; i++) begin
      checkOutput("addr_hold", imem_addr, pc);
      checkOutput("no_adv_stall", {31'd0, pc_advance}, 32'd0);
      tick();
      #1;
    end
    imem_req_ready = 1'b1;
    #1;
    checkOutput("accept_addr", imem_addr, pc);
    checkOutput("accept_adv", {31'd0, pc_advance}, 32'd1);
    exp_adv++;
    last_accept = cyc;
    tick();
    imem_req_ready = 1'b0;
    for (int i = 1; i < rsp_lat; i++) tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    if (deliver) sb.push_back('{pc: pc, instr: data});
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    checkOutput("load_valid", {31'd0, id_valid}, 32'd1);
    checkOutput("load_pc", id_pc, pc);
    checkOutput("load_instr", id_instr, data);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst            = 1'b1;
    pc_in          = '0;
    branchEnable   = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    id_ready       = 1'b1;
    tick();
    tick();
    #1;
    checkOutput("rst_id_valid", {31'd0, id_valid}, 32'd0);
    checkOutput("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("rst_addr", imem_addr, 32'd0);
    checkOutput("rst_adv", {31'd0, pc_advance}, 32'd0);
    checkOutput("rst_id_pc", id_pc, 32'd0);
    checkOutput("rst_id_instr", id_instr, 32'd0);

    // Basic fetch straight out of reset.
    tick();
    rst        = 1'b0;
    adv_before = adv_count;
    applyStimulus(32'h10, 32'hAABB0001, 0, 1, 1'b1);
    first_accept = last_accept;
    tick();
    checkOutput("basic_one_adv", 32'(adv_count - adv_before), 32'd1);

    // Back-to-back fetches for the three-cycle throughput check.
    applyStimulus(32'h14, 32'h0000_0014, 0, 1, 1'b1);
    first_accept = last_accept;
    applyStimulus(32'h18, 32'h0000_0018, 0, 1, 1'b1);
    checkOutput("throughput", 32'(last_accept - first_accept), 32'd3);

    // Memory stalls the request for four cycles.
    tick();
    adv_before = adv_count;
    applyStimulus(32'h20, 32'h2020_2020, 4, 1, 1'b1);
    tick();
    checkOutput("stall_one_adv", 32'(adv_count - adv_before), 32'd1);

    // Decode stalls for five cycles in HOLD.
    id_ready = 1'b0;
    applyStimulus(32'h30, 32'h3333_3333, 0, 2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      checkOutput("hold_valid", {31'd0, id_valid}, 32'd1);
      checkOutput("hold_instr", id_instr, 32'h3333_3333);
      checkOutput("hold_pc", id_pc, 32'h30);
      checkOutput("hold_no_req", {31'd0, imem_req_valid}, 32'd0);
    end
    id_ready = 1'b1;
    tick();

    // Redirect while WAIT: the stale response must be dropped.
    pc_in = 32'h40;
    waitReq();
    imem_req_ready = 1'b1;
    exp_adv++;
    tick();
    imem_req_ready = 1'b0;
    pc_in          = 32'h80;
    branchEnable   = 1'b1;
    tick();
    branchEnable = 1'b0;
    #1;
    checkOutput("wait_br_no_req", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD0000;
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    checkOutput("stale_dropped", {31'd0, id_valid}, 32'd0);
    checkOutput("reissue_addr", imem_addr, 32'h80);
    applyStimulus(32'h80, 32'h12345678, 0, 1, 1'b1);
    tick();

    // Redirect in the same cycle as acceptance in REQ.
    pc_in = 32'h50;
    waitReq();
    imem_req_ready = 1'b1;
    branchEnable   = 1'b1;
    #1;
    checkOutput("req_br_adv", {31'd0, pc_advance}, 32'd1);
    exp_adv++;
    tick();
    imem_req_ready = 1'b0;
    branchEnable   = 1'b0;
    pc_in          = 32'h60;
    #1;
    checkOutput("req_br_no_req", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_0050;
    tick();
    imem_rsp_valid = 1'b0;
    applyStimulus(32'h60, 32'h6666_0000, 0, 1, 1'b1);
    tick();

    // Redirect in HOLD while decode is stalled: the instruction is lost.
    id_ready = 1'b0;
    applyStimulus(32'h70, 32'h7777_0000, 0, 1, 1'b0);
    branchEnable = 1'b1;
    tick();
    branchEnable = 1'b0;
    #1;
    checkOutput("hold_br_flush", {31'd0, id_valid}, 32'd0);
    id_ready = 1'b1;

    // Redirect together with id_ready in HOLD: decode still takes the
    // instruction.
    applyStimulus(32'hB0, 32'hBBBB_0000, 0, 1, 1'b1);
    branchEnable = 1'b1;
    tick();
    branchEnable = 1'b0;
    #1;
    checkOutput("hold_br_rdy_flush", {31'd0, id_valid}, 32'd0);

    // PC values at the top of the address space are passed through unchanged.
    applyStimulus(32'hFFFF_FFFF, 32'hF0F0_F0F0, 0, 1, 1'b1);
    applyStimulus(32'h0000_0000, 32'h0F0F_0F0F, 0, 1, 1'b1);
    tick();

    // Reset during WAIT, followed by a stray response.
    pc_in = 32'h90;
    waitReq();
    imem_req_ready = 1'b1;
    exp_adv++;
    tick();
    imem_req_ready = 1'b0;
    rst            = 1'b1;
    tick();
    rst            = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h5757_5757;
    #1;
    checkOutput("rstw_idle_req", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("rstw_id_valid", {31'd0, id_valid}, 32'd0);
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    checkOutput("rstw_req", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("rstw_stray_ign", {31'd0, id_valid}, 32'd0);
    applyStimulus(32'h94, 32'h9494_9494, 0, 1, 1'b1);
    tick();
    tick();

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    checkOutput("adv_total", 32'(adv_count), 32'(exp_adv));

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
